spi_cmd_regfile: RTL and testbench

SPI_CMD_REGFILE -- requirements
Module: spi_cmd_regfile

---
 rtl/fpga_slave_pkg.sv | 28 ++
 rtl/spi_byte_phy.sv | 71 +++++++
 rtl/spi_cmd_regfile.sv | 181 ++++++++++++++++++
 tb/tb_spi_cmd_regfile.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_slave_pkg.sv
// Shared definitions for the SPI command/register slave: header decode
// constants, FSM state encoding and legal parameter ranges.
package fpga_slave_pkg;

    localparam int DATA_BYTES_MIN = 1;
    localparam int DATA_BYTES_MAX = 4;
    localparam int NUM_REGS_MIN   = 1;
    localparam int NUM_REGS_MAX   = 64;

    localparam logic [7:0] HDR_WR_MASK  = 8'h80;
    localparam logic [7:0] HDR_WR_VAL   = 8'h80;
    localparam logic [7:0] HDR_RD_MASK  = 8'hC0;
    localparam logic [7:0] HDR_RD_VAL   = 8'h40;
    localparam logic [7:0] HDR_CMD_MASK = 8'hC0;
    localparam logic [7:0] HDR_CMD_VAL  = 8'h00;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_DATA = 2'd1,
        RD_DATA = 2'd2
    } state_t;

    function automatic logic hdr_match(input logic [7:0] b, input logic [7:0] mask,
                                       input logic [7:0] val);
        return (b & mask) == val;
    endfunction

endpackage

// File: rtl/spi_byte_phy.sv
// SPI mode-0 byte layer: pin synchronisers, edge detect, MOSI byte
// assembly and the MISO shift register, all in the clk_in domain.
module spi_byte_phy (
    input  logic       clk_in,
    input  logic       sys_rst_n,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       cs_n,
    input  logic       tx_load,
    input  logic [7:0] tx_byte,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_abort,
    output logic       cs_fall,
    output logic       cs_active,
    output logic       tx_bit
);
    // Index 1 is the synchronised copy, index 2 its one-cycle-old history.
    logic [2:0] sclk_ff;
    logic [2:0] cs_ff;
    logic [1:0] mosi_ff;
    logic [2:0] bit_cnt;
    logic [6:0] rx_shift;
    logic [7:0] tx_shift;
    logic       sclk_rise;
    logic       sclk_fall;
    logic       cs_rise;

    assign sclk_rise = sclk_ff[1] & ~sclk_ff[2];
    assign sclk_fall = ~sclk_ff[1] & sclk_ff[2];
    assign cs_rise   = cs_ff[1] & ~cs_ff[2];
    assign cs_fall   = ~cs_ff[1] & cs_ff[2];
    assign cs_active = ~cs_ff[1];
    assign tx_bit    = tx_shift[7];

    always_ff @(posedge clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sclk_ff     <= '0;
            cs_ff       <= '0;
            mosi_ff     <= '0;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            byte_valid  <= 1'b0;
            byte_data   <= '0;
            frame_abort <= 1'b0;
        end else begin
            sclk_ff     <= {sclk_ff[1:0], sclk};
            cs_ff       <= {cs_ff[1:0], cs_n};
            mosi_ff     <= {mosi_ff[0], mosi};
            byte_valid  <= 1'b0;
            frame_abort <= 1'b0;
            if (cs_rise) begin
                if (bit_cnt != 3'd0) frame_abort <= 1'b1;
                bit_cnt <= '0;
            end else if (cs_active && sclk_rise) begin
                if (bit_cnt == 3'd7) begin
                    byte_valid <= 1'b1;
                    byte_data  <= {rx_shift, mosi_ff[1]};
                    bit_cnt    <= '0;
                end else begin
                    rx_shift <= {rx_shift[5:0], mosi_ff[1]};
                    bit_cnt  <= bit_cnt + 3'd1;
                end
            end
            if (tx_load) tx_shift <= tx_byte;
            else if (cs_active && sclk_fall) tx_shift <= {tx_shift[6:0], 1'b0};
        end
    end

endmodule

// File: rtl/spi_cmd_regfile.sv
// SPI-addressed register file with write/read/action-command headers,
// inter-byte timeout and error pulses.
//   state   | meaning
//   IDLE    | next byte is a header
//   WR_DATA | collecting write data bytes, LSB byte first
//   RD_DATA | returning register bytes on miso, one per cs_n window
module spi_cmd_regfile
    import fpga_slave_pkg::*;
#(
    parameter int DATA_BYTES  = 2,
    parameter int NUM_REGS    = 32,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                           clk_in,
    input  logic                           sys_rst_n,
    input  logic                           sclk,
    input  logic                           mosi,
    input  logic                           cs_n,
    output logic                           miso,
    output logic [NUM_REGS*DATA_BYTES*8-1:0] regs_flat,
    output logic                           wr_strobe,
    output logic [5:0]                     wr_addr,
    output logic                           cmd_valid,
    output logic [5:0]                     cmd_code,
    output logic                           frame_err,
    output logic                           addr_err
);
    localparam int W  = DATA_BYTES * 8;
    localparam int WD = (DATA_BYTES > 1) ? W - 8 : 8;
    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [1:0]    LAST_IDX = 2'(DATA_BYTES - 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYC - 1);

    state_t         state;
    logic [6:0]     addr_q;
    logic [1:0]     byte_idx;
    logic [TW-1:0]  tmo_cnt;
    logic [WD-1:0]  wdata;
    logic [WD-1:0]  wdata_next;
    logic [W-1:0]   word_cat;
    logic [W-1:0]   regs [2**IW];
    logic           byte_valid;
    logic [7:0]     byte_data;
    logic           frame_abort;
    logic           cs_fall;
    logic           cs_active;
    logic           tx_bit;
    logic           tx_load;
    logic [7:0]     tx_byte;
    logic           addr_ok;
    logic [IW-1:0]  idx;
    logic [31:0]    rd_pad;

    spi_byte_phy u_phy (
        .clk_in      (clk_in),
        .sys_rst_n   (sys_rst_n),
        .sclk        (sclk),
        .mosi        (mosi),
        .cs_n        (cs_n),
        .tx_load     (tx_load),
        .tx_byte     (tx_byte),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .frame_abort (frame_abort),
        .cs_fall     (cs_fall),
        .cs_active   (cs_active),
        .tx_bit      (tx_bit)
    );

    // Earlier data bytes shift down from the top so the final byte completes the word.
    generate
        if (DATA_BYTES > 1) begin : g_multi
            assign word_cat   = {byte_data, wdata};
            assign wdata_next = word_cat[W-1:8];
        end else begin : g_single
            assign word_cat   = byte_data;
            assign wdata_next = wdata;
        end
        for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
            assign regs_flat[k*W +: W] = regs[k];
        end
    endgenerate

    assign addr_ok = addr_q < 7'(NUM_REGS);
    assign idx     = addr_q[IW-1:0];
    assign rd_pad  = 32'(regs[idx]);
    assign tx_load = (state == RD_DATA) && cs_fall;

    always_comb begin
        tx_byte = 8'h00;
        if (addr_ok) begin
            case (byte_idx)
                2'd0:    tx_byte = rd_pad[7:0];
                2'd1:    tx_byte = rd_pad[15:8];
                2'd2:    tx_byte = rd_pad[23:16];
                default: tx_byte = rd_pad[31:24];
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            addr_q    <= '0;
            byte_idx  <= '0;
            tmo_cnt   <= '0;
            wdata     <= '0;
            for (int k = 0; k < 2**IW; k++) regs[k] <= '0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            cmd_valid <= 1'b0;
            cmd_code  <= '0;
            frame_err <= 1'b0;
            addr_err  <= 1'b0;
            miso      <= 1'b0;
        end else begin
            wr_strobe <= 1'b0;
            cmd_valid <= 1'b0;
            addr_err  <= 1'b0;
            frame_err <= frame_abort;
            miso      <= (state == RD_DATA) && cs_active && tx_bit;
            case (state)
                IDLE: begin
                    if (byte_valid) begin
                        byte_idx <= '0;
                        tmo_cnt  <= TMO_LOAD;
                        if (hdr_match(byte_data, HDR_WR_MASK, HDR_WR_VAL)) begin
                            addr_q <= byte_data[6:0];
                            state  <= WR_DATA;
                        end else if (hdr_match(byte_data, HDR_RD_MASK, HDR_RD_VAL)) begin
                            addr_q <= {1'b0, byte_data[5:0]};
                            state  <= RD_DATA;
                            if ({1'b0, byte_data[5:0]} >= 7'(NUM_REGS)) addr_err <= 1'b1;
                        end else begin
                            cmd_valid <= 1'b1;
                            cmd_code  <= byte_data[5:0];
                        end
                    end
                end
                WR_DATA: begin
                    if (byte_valid) begin
                        tmo_cnt <= TMO_LOAD;
                        wdata   <= wdata_next;
                        if (byte_idx == LAST_IDX) begin
                            state <= IDLE;
                            if (addr_ok) begin
                                regs[idx] <= word_cat;
                                wr_strobe <= 1'b1;
                                wr_addr   <= addr_q[5:0];
                            end else begin
                                addr_err <= 1'b1;
                            end
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end else if (tmo_cnt == '0) begin
                        state     <= IDLE;
                        frame_err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
                end
                RD_DATA: begin
                    if (byte_valid) begin
                        tmo_cnt <= TMO_LOAD;
                        if (byte_idx == LAST_IDX) state <= IDLE;
                        else byte_idx <= byte_idx + 2'd1;
                    end else if (tmo_cnt == '0) begin
                        state     <= IDLE;
                        frame_err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cmd_regfile.sv
// Self-checking bench for spi_cmd_regfile: directed scenarios plus random
// transactions scored against a transaction-level register model.
module tb_spi_cmd_regfile;
    localparam int DB  = 2;
    localparam int NR  = 32;
    localparam int TMO = 50000;
    localparam int W   = DB * 8;
    localparam int HP  = 6;

    logic            clk_in = 1'b0;
    logic            sys_rst_n = 1'b0;
    logic            sclk = 1'b0;
    logic            mosi = 1'b0;
    logic            cs_n = 1'b1;
    logic            miso;
    logic [NR*W-1:0] regs_flat;
    logic            wr_strobe;
    logic [5:0]      wr_addr;
    logic            cmd_valid;
    logic [5:0]      cmd_code;
    logic            frame_err;
    logic            addr_err;

    int tests = 0;
    int fails = 0;
    int n_wr = 0, n_cmd = 0, n_ferr = 0, n_aerr = 0;
    int e_wr = 0, e_cmd = 0, e_ferr = 0, e_aerr = 0;
    logic [5:0] last_wr_addr = '0, last_cmd = '0;
    logic [5:0] e_wr_addr = '0, e_cmd_code = '0;
    logic [W-1:0] model [NR];

    always #5 clk_in = ~clk_in;

    spi_cmd_regfile #(.DATA_BYTES(DB), .NUM_REGS(NR), .TIMEOUT_CYC(TMO)) dut (
        .clk_in    (clk_in),
        .sys_rst_n (sys_rst_n),
        .sclk      (sclk),
        .mosi      (mosi),
        .cs_n      (cs_n),
        .miso      (miso),
        .regs_flat (regs_flat),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .frame_err (frame_err),
        .addr_err  (addr_err)
    );

    always @(negedge clk_in) begin
        if (sys_rst_n) begin
            if (wr_strobe) begin n_wr++; last_wr_addr = wr_addr; end
            if (cmd_valid) begin n_cmd++; last_cmd = cmd_code; end
            if (frame_err) n_ferr++;
            if (addr_err)  n_aerr++;
        end
    end

    initial begin
        #950000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] reg_at(input int k);
        return regs_flat[k*W +: W];
    endfunction

    task automatic check_counts(input string tag);
        check({tag, "_wr_count"},   n_wr,   e_wr);
        check({tag, "_cmd_count"},  n_cmd,  e_cmd);
        check({tag, "_ferr_count"}, n_ferr, e_ferr);
        check({tag, "_aerr_count"}, n_aerr, e_aerr);
        check({tag, "_wr_addr"},    last_wr_addr, e_wr_addr);
        check({tag, "_cmd_code"},   last_cmd, e_cmd_code);
        check({tag, "_miso_cs_high"}, miso, 1'b0);
    endtask

    task automatic check_all_regs(input string tag);
        for (int k = 0; k < NR; k++) check(tag, reg_at(k), model[k]);
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        cs_n = 1'b0;
        repeat (8) @(negedge clk_in);
        for (int i = 7; i >= 0; i--) begin
            mosi = tx[i];
            repeat (HP) @(negedge clk_in);
            rx[i] = miso;
            sclk = 1'b1;
            repeat (HP) @(negedge clk_in);
            sclk = 1'b0;
        end
        repeat (HP) @(negedge clk_in);
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (8) @(negedge clk_in);
    endtask

    task automatic do_write(input logic [6:0] a, input logic [W-1:0] d);
        logic [7:0] rx;
        spi_byte({1'b1, a}, rx);
        check("wr_hdr_miso", rx, 8'h00);
        for (int b = 0; b < DB; b++) begin
            spi_byte(d[b*8 +: 8], rx);
            check("wr_data_miso", rx, 8'h00);
        end
        repeat (4) @(negedge clk_in);
        if (int'(a) < NR) begin
            model[a] = d;
            e_wr++;
            e_wr_addr = a[5:0];
            check("wr_reg", reg_at(int'(a)), model[a]);
        end else begin
            e_aerr++;
        end
        check_counts("write");
    endtask

    task automatic do_read(input logic [5:0] a);
        logic [7:0]   rx;
        logic [W-1:0] got;
        logic [W-1:0] exp;
        spi_byte({2'b01, a}, rx);
        for (int b = 0; b < DB; b++) begin
            spi_byte(8'($urandom_range(0, 255)), rx);
            got[b*8 +: 8] = rx;
        end
        repeat (4) @(negedge clk_in);
        exp = (int'(a) < NR) ? model[a] : '0;
        if (int'(a) >= NR) e_aerr++;
        check("rd_data", got, exp);
        check_counts("read");
    endtask

    task automatic do_cmd(input logic [5:0] c);
        logic [7:0] rx;
        spi_byte({2'b00, c}, rx);
        repeat (4) @(negedge clk_in);
        e_cmd++;
        e_cmd_code = c;
        check_counts("cmd");
    endtask

    initial begin
        logic [7:0] rx;
        logic [7:0] part;
        int w;
        int start;
        for (int k = 0; k < NR; k++) model[k] = '0;

        repeat (5) @(negedge clk_in);
        check_all_regs("reset_regs");
        check("reset_wr_strobe", wr_strobe, 1'b0);
        check("reset_miso", miso, 1'b0);
        check("reset_errs", {frame_err, addr_err, cmd_valid}, 3'b000);
        sys_rst_n = 1'b1;
        repeat (5) @(negedge clk_in);

        do_write(7'h11, 16'h0064);
        do_write(7'h1E, 16'h0032);
        do_read(6'h1E);
        do_cmd(6'h06);
        check_all_regs("cmd_regs");

        // Inter-byte timeout in the middle of a write frame.
        spi_byte(8'h93, rx);
        spi_byte(8'h3C, rx);
        start = n_ferr;
        w = 0;
        while (n_ferr == start && w < TMO + 100) begin
            @(negedge clk_in);
            w++;
        end
        check("tmo_latency_window", (w >= TMO - 40 && w <= TMO + 10), 1'b1);
        e_ferr++;
        repeat (4) @(negedge clk_in);
        check_counts("timeout");
        check("tmo_reg13", reg_at(8'h13), model[8'h13]);
        do_cmd(6'h06);

        do_write(7'h3F, 16'h3412);
        check_all_regs("oor_regs");

        // cs_n raised after 4 bits of 0x91.
        part = 8'h91;
        cs_n = 1'b0;
        repeat (8) @(negedge clk_in);
        for (int i = 7; i >= 4; i--) begin
            mosi = part[i];
            repeat (HP) @(negedge clk_in);
            sclk = 1'b1;
            repeat (HP) @(negedge clk_in);
            sclk = 1'b0;
        end
        repeat (HP) @(negedge clk_in);
        cs_n = 1'b1;
        repeat (8) @(negedge clk_in);
        e_ferr++;
        check_counts("partial");
        do_cmd(6'h05);

        for (int t = 0; t < 30; t++) begin
            case ($urandom_range(0, 2))
                0: begin
                    if ($urandom_range(0, 3) == 0)
                        do_write(7'($urandom_range(NR, 127)), W'($urandom));
                    else
                        do_write(7'($urandom_range(0, NR - 1)), W'($urandom));
                end
                1: do_read(6'($urandom_range(0, 63)));
                default: do_cmd(6'($urandom_range(0, 63)));
            endcase
        end
        check_all_regs("random_regs");

        // Reset in the middle of a write frame.
        spi_byte(8'h85, rx);
        spi_byte(8'hAA, rx);
        sys_rst_n = 1'b0;
        #1;
        check("midrst_regs_zero", (regs_flat === '0), 1'b1);
        check("midrst_pulses", {wr_strobe, cmd_valid, frame_err, addr_err, miso}, 5'b0);
        check("midrst_addr_code", {wr_addr, cmd_code}, 12'h000);
        for (int k = 0; k < NR; k++) model[k] = '0;
        repeat (5) @(negedge clk_in);
        sys_rst_n = 1'b1;
        repeat (5) @(negedge clk_in);
        do_cmd(6'h06);
        check_all_regs("post_rst_regs");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
